// File: rtl/layer_scan_ctrl_if.sv
// Bus bundle between layer_scan_ctrl (master side) and its environment:
// command inputs, layer memory read/write ports and the pixel stream to the mixer.
interface layer_scan_ctrl_if #(
    parameter int X_LIMIT = 240,
    parameter int Y_LIMIT = 240,
    parameter int ADDR_W  = $clog2(X_LIMIT) + $clog2(Y_LIMIT)
);
    localparam int XW = $clog2(X_LIMIT);
    localparam int YW = $clog2(Y_LIMIT);

    logic              START;
    logic              FILL_REQ;
    logic [XW-1:0]     FILL_X0;
    logic [XW-1:0]     FILL_X1;
    logic [YW-1:0]     FILL_Y0;
    logic [YW-1:0]     FILL_Y1;
    logic              FILL_VALUE;
    logic              FILL_ACK;
    logic              BUSY;
    logic              FRAME_DONE;
    logic              FILL_DONE;
    logic [ADDR_W-1:0] ROM_ADDRESS;
    logic              ROM_DATA;
    logic              PIX_VALID;
    logic              PIX_READY;
    logic              PIX_DATA;
    logic [XW-1:0]     PIX_X;
    logic [YW-1:0]     PIX_Y;
    logic              PIX_LAST;
    logic              WRITE_ROM;
    logic [ADDR_W-1:0] WRITE_ROM_ADDRESS;
    logic              WRITE_ROM_DATA;

    modport master (
        input  START, FILL_REQ, FILL_X0, FILL_X1, FILL_Y0, FILL_Y1, FILL_VALUE,
               ROM_DATA, PIX_READY,
        output FILL_ACK, BUSY, FRAME_DONE, FILL_DONE, ROM_ADDRESS,
               PIX_VALID, PIX_DATA, PIX_X, PIX_Y, PIX_LAST,
               WRITE_ROM, WRITE_ROM_ADDRESS, WRITE_ROM_DATA
    );

    modport slave (
        output START, FILL_REQ, FILL_X0, FILL_X1, FILL_Y0, FILL_Y1, FILL_VALUE,
               ROM_DATA, PIX_READY,
        input  FILL_ACK, BUSY, FRAME_DONE, FILL_DONE, ROM_ADDRESS,
               PIX_VALID, PIX_DATA, PIX_X, PIX_Y, PIX_LAST,
               WRITE_ROM, WRITE_ROM_ADDRESS, WRITE_ROM_DATA
    );
endinterface

// File: rtl/layer_scan_ctrl.sv
// Layer bitmap controller: raster frame scan to the mixer and rectangle fill via the write port.
// Define LAYER_SCAN_MIRROR_X_EN to read each row right-to-left (horizontally mirrored output).
module layer_scan_ctrl #(
    parameter int X_LIMIT = 240,
    parameter int Y_LIMIT = 240,
    parameter int ADDR_W  = $clog2(X_LIMIT) + $clog2(Y_LIMIT)
) (
    input  logic              CLK,
    input  logic              RESET,
    layer_scan_ctrl_if.master bus
);
    localparam int XW = $clog2(X_LIMIT);
    localparam int YW = $clog2(Y_LIMIT);
    localparam logic [XW-1:0] XMAX = XW'(X_LIMIT - 1);
    localparam logic [YW-1:0] YMAX = YW'(Y_LIMIT - 1);
    localparam bit X_CLAMP = (2 ** XW) > X_LIMIT;
    localparam bit Y_CLAMP = (2 ** YW) > Y_LIMIT;

    typedef enum logic [1:0] {IDLE, SCAN, FILL, FILL_END} state_t;

    state_t state_q, state_d;
    logic pend_q, pend_d;

    // scan: f_* describe the pixel whose address is on ROM_ADDRESS
    logic [XW-1:0]     f_x_q, f_x_d;
    logic [YW-1:0]     f_y_q, f_y_d;
    logic [ADDR_W-1:0] f_base_q, f_base_d;
    logic              f_more_q, f_more_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              pix_valid_q, pix_valid_d;
    logic [XW-1:0]     pix_x_q, pix_x_d;
    logic [YW-1:0]     pix_y_q, pix_y_d;
    logic              pix_last_q, pix_last_d;
    logic              fresh_q, fresh_d;
    logic              hold_q, hold_d;
    logic              frame_done_q, frame_done_d;

    // fill
    logic [XW-1:0]     x0_q, x0_d, x1_q, x1_d, w_x_q, w_x_d;
    logic [YW-1:0]     y0_q, y0_d, y1_q, y1_d, w_y_q, w_y_d;
    logic [ADDR_W-1:0] w_base_q, w_base_d;
    logic              val_q, val_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              wr_data_q, wr_data_d;
    logic              fill_ack_q, fill_ack_d;
    logic              fill_done_q, fill_done_d;

    logic take;

    function automatic logic [ADDR_W-1:0] col(input logic [XW-1:0] x);
`ifdef LAYER_SCAN_MIRROR_X_EN
        return ADDR_W'(X_LIMIT - 1) - ADDR_W'(x);
`else
        return ADDR_W'(x);
`endif
    endfunction

    function automatic logic [XW-1:0] clamp_x(input logic [XW-1:0] v);
        if (X_CLAMP && (v > XMAX)) return XMAX;
        return v;
    endfunction

    function automatic logic [YW-1:0] clamp_y(input logic [YW-1:0] v);
        if (Y_CLAMP && (v > YMAX)) return YMAX;
        return v;
    endfunction

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        f_x_d        = f_x_q;
        f_y_d        = f_y_q;
        f_base_d     = f_base_q;
        f_more_d     = f_more_q;
        rom_addr_d   = rom_addr_q;
        pix_valid_d  = pix_valid_q;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_last_d   = pix_last_q;
        fresh_d      = fresh_q;
        hold_d       = hold_q;
        frame_done_d = 1'b0;
        x0_d         = x0_q;
        x1_d         = x1_q;
        y0_d         = y0_q;
        y1_d         = y1_q;
        w_x_d        = w_x_q;
        w_y_d        = w_y_q;
        w_base_d     = w_base_q;
        val_d        = val_q;
        wr_d         = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        fill_ack_d   = 1'b0;
        fill_done_d  = 1'b0;
        take         = pix_valid_q & bus.PIX_READY;

        if (state_q != IDLE && bus.START) pend_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (bus.FILL_REQ) begin
                    state_d    = FILL;
                    fill_ack_d = 1'b1;
                    if (bus.START) pend_d = 1'b1;
                    x0_d     = clamp_x(bus.FILL_X0);
                    x1_d     = clamp_x(bus.FILL_X1);
                    y0_d     = clamp_y(bus.FILL_Y0);
                    y1_d     = clamp_y(bus.FILL_Y1);
                    val_d    = bus.FILL_VALUE;
                    w_x_d    = x0_d;
                    w_y_d    = y0_d;
                    // one-off row base at accept; the per-write path only adds
                    w_base_d = ADDR_W'(y0_d) * ADDR_W'(X_LIMIT);
                end else if (bus.START || pend_q) begin
                    state_d    = SCAN;
                    pend_d     = 1'b0;
                    f_x_d      = '0;
                    f_y_d      = '0;
                    f_base_d   = '0;
                    f_more_d   = 1'b1;
                    rom_addr_d = col('0);
                end
            end
            SCAN: begin
                // ROM_DATA is only valid the cycle after a pixel is presented; keep a copy for stalls
                if (fresh_q) begin
                    hold_d  = bus.ROM_DATA;
                    fresh_d = 1'b0;
                end
                if (take && pix_last_q) begin
                    pix_valid_d  = 1'b0;
                    pix_last_d   = 1'b0;
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end else if ((!pix_valid_q || take) && f_more_q) begin
                    pix_valid_d = 1'b1;
                    pix_x_d     = f_x_q;
                    pix_y_d     = f_y_q;
                    pix_last_d  = (f_x_q == XMAX) && (f_y_q == YMAX);
                    fresh_d     = 1'b1;
                    if ((f_x_q == XMAX) && (f_y_q == YMAX)) begin
                        f_more_d = 1'b0;
                    end else if (f_x_q == XMAX) begin
                        f_x_d      = '0;
                        f_y_d      = f_y_q + 1'b1;
                        f_base_d   = f_base_q + ADDR_W'(X_LIMIT);
                        rom_addr_d = f_base_q + ADDR_W'(X_LIMIT) + col('0);
                    end else begin
                        f_x_d      = f_x_q + 1'b1;
                        rom_addr_d = f_base_q + col(f_x_q + 1'b1);
                    end
                end else if (take) begin
                    pix_valid_d = 1'b0;
                end
            end
            FILL: begin
                if ((x0_q > x1_q) || (y0_q > y1_q)) begin
                    state_d = FILL_END;
                end else begin
                    wr_d      = 1'b1;
                    wr_addr_d = w_base_q + ADDR_W'(w_x_q);
                    wr_data_d = val_q;
                    if (w_x_q == x1_q) begin
                        w_x_d = x0_q;
                        if (w_y_q == y1_q) begin
                            state_d = FILL_END;
                        end else begin
                            w_y_d    = w_y_q + 1'b1;
                            w_base_d = w_base_q + ADDR_W'(X_LIMIT);
                        end
                    end else begin
                        w_x_d = w_x_q + 1'b1;
                    end
                end
            end
            FILL_END: begin
                fill_done_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q      <= IDLE;
            pend_q       <= 1'b0;
            f_x_q        <= '0;
            f_y_q        <= '0;
            f_base_q     <= '0;
            f_more_q     <= 1'b0;
            rom_addr_q   <= '0;
            pix_valid_q  <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_last_q   <= 1'b0;
            fresh_q      <= 1'b0;
            hold_q       <= 1'b0;
            frame_done_q <= 1'b0;
            x0_q         <= '0;
            x1_q         <= '0;
            y0_q         <= '0;
            y1_q         <= '0;
            w_x_q        <= '0;
            w_y_q        <= '0;
            w_base_q     <= '0;
            val_q        <= 1'b0;
            wr_q         <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 1'b0;
            fill_ack_q   <= 1'b0;
            fill_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            f_x_q        <= f_x_d;
            f_y_q        <= f_y_d;
            f_base_q     <= f_base_d;
            f_more_q     <= f_more_d;
            rom_addr_q   <= rom_addr_d;
            pix_valid_q  <= pix_valid_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_last_q   <= pix_last_d;
            fresh_q      <= fresh_d;
            hold_q       <= hold_d;
            frame_done_q <= frame_done_d;
            x0_q         <= x0_d;
            x1_q         <= x1_d;
            y0_q         <= y0_d;
            y1_q         <= y1_d;
            w_x_q        <= w_x_d;
            w_y_q        <= w_y_d;
            w_base_q     <= w_base_d;
            val_q        <= val_d;
            wr_q         <= wr_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            fill_ack_q   <= fill_ack_d;
            fill_done_q  <= fill_done_d;
        end
    end

    assign bus.BUSY              = (state_q != IDLE);
    assign bus.FILL_ACK          = fill_ack_q;
    assign bus.FILL_DONE         = fill_done_q;
    assign bus.FRAME_DONE        = frame_done_q;
    assign bus.ROM_ADDRESS       = rom_addr_q;
    assign bus.PIX_VALID         = pix_valid_q;
    assign bus.PIX_DATA          = fresh_q ? bus.ROM_DATA : hold_q;
    assign bus.PIX_X             = pix_x_q;
    assign bus.PIX_Y             = pix_y_q;
    assign bus.PIX_LAST          = pix_last_q;
    assign bus.WRITE_ROM         = wr_q;
    assign bus.WRITE_ROM_ADDRESS = wr_addr_q;
    assign bus.WRITE_ROM_DATA    = wr_data_q;
endmodule
